// File: rtl/note_pkg.sv
// Shared note codes, nominal frequency table and classification window helper
// for the note detector.
package note_pkg;

    localparam int unsigned CODE_W    = 4;
    localparam int unsigned PER_W     = 24;
    localparam int unsigned NUM_CODES = 14;

    localparam logic [CODE_W-1:0] DO2_CODE  = 4'd0;
    localparam logic [CODE_W-1:0] DO3_CODE  = 4'd1;
    localparam logic [CODE_W-1:0] FA2_CODE  = 4'd2;
    localparam logic [CODE_W-1:0] LA1_CODE  = 4'd3;
    localparam logic [CODE_W-1:0] LA2_CODE  = 4'd4;
    localparam logic [CODE_W-1:0] MI2_CODE  = 4'd5;
    localparam logic [CODE_W-1:0] RE2_CODE  = 4'd6;
    localparam logic [CODE_W-1:0] REB2_CODE = 4'd7;
    localparam logic [CODE_W-1:0] REB3_CODE = 4'd8;
    localparam logic [CODE_W-1:0] SIB2_CODE = 4'd9;
    localparam logic [CODE_W-1:0] SOL2_CODE = 4'd10;
    localparam logic [CODE_W-1:0] MUTE_CODE = 4'd11;
    localparam logic [CODE_W-1:0] RE1_CODE  = 4'd12;
    localparam logic [CODE_W-1:0] RE3_CODE  = 4'd13;
    localparam logic [CODE_W-1:0] UNK_CODE  = 4'd15;

    // Nominal frequency per code in centi-Hz; 0 marks codes that are not tones.
    localparam int unsigned FREQ_CHZ [NUM_CODES] = '{
        26163, 52325, 34923, 22000, 44000, 32963, 29366,
        27718, 55437, 46616, 39200, 0,     14683, 58733
    };

    typedef struct packed {
        logic [PER_W-1:0] lo;
        logic [PER_W-1:0] hi;
    } win_t;

    // Open window: a period matches when lo < period < hi. lo is the floor and
    // hi the ceiling of the exact bounds, so an exact-boundary period is outside.
    function automatic win_t period_window(input int unsigned clk_hz,
                                           input int unsigned tol_pct,
                                           input int unsigned freq_chz);
        logic [63:0] num_lo;
        logic [63:0] num_hi;
        logic [63:0] den;
        win_t        w;
        if (freq_chz == 0) begin
            w.lo = '1;
            w.hi = '0;
        end else begin
            den    = 64'(freq_chz);
            num_lo = 64'(clk_hz) * 64'(100 - tol_pct);
            num_hi = 64'(clk_hz) * 64'(100 + tol_pct);
            w.lo   = PER_W'(num_lo / den);
            w.hi   = PER_W'((num_hi + den - 64'd1) / den);
        end
        return w;
    endfunction

endpackage

// File: rtl/note_classify.sv
// Combinational period-to-note classifier: returns the code whose tolerance
// window contains the period, or UNK_CODE.
module note_classify
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TOL_PCT = 2
) (
    input  logic [PER_W-1:0]  period,
    output logic [CODE_W-1:0] code_c
);

    logic [NUM_CODES-1:0] hit;

    for (genvar i = 0; i < NUM_CODES; i++) begin : g_win
        localparam win_t WIN = period_window(CLK_HZ, TOL_PCT, FREQ_CHZ[i]);
        assign hit[i] = (period > WIN.lo) && (period < WIN.hi);
    end

    // Windows do not overlap at sane tolerances; lowest code wins otherwise.
    always_comb begin
        code_c = UNK_CODE;
        for (int i = NUM_CODES - 1; i >= 0; i--) begin
            if (hit[i]) code_c = CODE_W'(i);
        end
    end

endmodule

// File: rtl/note_detector.sv
// Measures the period of a square-wave tone, classifies it and reports a note
// once it is stable. Define NOTE_DET_CNT_EN to enable the note_chg counter.
module note_detector
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned STABLE_CNT = 3,
    parameter int unsigned TOL_PCT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              nota,
    output logic [CODE_W-1:0] note_code,
    output logic              note_valid,
    output logic              note_chg,
    output logic [PER_W-1:0]  period,
    output logic [7:0]        note_cnt
);

    localparam int unsigned      MUTE_CYC = CLK_HZ / 50;
    localparam int unsigned      MC_W     = 3;
    localparam logic [MC_W-1:0]  STABLE   = MC_W'(STABLE_CNT);
    localparam logic [PER_W-1:0] CNT_MAX  = '1;
    localparam logic [PER_W-1:0] MUTE_LIM = PER_W'(MUTE_CYC);

    typedef enum logic {S_WAIT = 1'b0, S_MEAS = 1'b1} state_t;

    state_t            state, state_nx;
    logic              sync1, sync2, sync3, edge_q;
    logic [PER_W-1:0]  cnt, cnt_nx, period_nx, meas_c;
    logic [CODE_W-1:0] cand, cand_nx, class_c, code_nx;
    logic [MC_W-1:0]   match_cnt, match_nx;
    logic              valid_nx, chg_nx;

    // Two-flop synchronizer plus registered rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync1  <= nota;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= sync2 & ~sync3;
        end
    end

    assign meas_c = (cnt == CNT_MAX) ? CNT_MAX : cnt + PER_W'(1);

    note_classify #(
        .CLK_HZ  (CLK_HZ),
        .TOL_PCT (TOL_PCT)
    ) u_classify (
        .period (meas_c),
        .code_c (class_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_WAIT;
            cnt        <= '0;
            period     <= '0;
            cand       <= MUTE_CODE;
            match_cnt  <= '0;
            note_code  <= MUTE_CODE;
            note_valid <= 1'b0;
            note_chg   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            period     <= period_nx;
            cand       <= cand_nx;
            match_cnt  <= match_nx;
            note_code  <= code_nx;
            note_valid <= valid_nx;
            note_chg   <= chg_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        period_nx = period;
        cand_nx   = cand;
        match_nx  = match_cnt;
        code_nx   = note_code;
        valid_nx  = note_valid;
        chg_nx    = 1'b0;

        case (state)
            S_WAIT: begin
                if (edge_q) begin
                    cnt_nx   = '0;
                    state_nx = S_MEAS;
                end
            end
            S_MEAS: begin
                // An edge coinciding with the timeout still closes a period.
                if (edge_q) begin
                    period_nx = meas_c;
                    cnt_nx    = '0;
                    if (class_c == cand) begin
                        if (match_cnt < STABLE) match_nx = match_cnt + MC_W'(1);
                    end else begin
                        cand_nx  = class_c;
                        match_nx = MC_W'(1);
                    end
                end else if (cnt >= MUTE_LIM) begin
                    state_nx = S_WAIT;
                    cnt_nx   = '0;
                    cand_nx  = MUTE_CODE;
                    match_nx = STABLE;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + PER_W'(1);
                end
            end
            default: state_nx = S_WAIT;
        endcase

        // Publish a confirmed candidate only when it differs from the report.
        if ((match_cnt >= STABLE) && ((cand != note_code) || !note_valid)) begin
            code_nx  = cand;
            valid_nx = 1'b1;
            chg_nx   = 1'b1;
        end
    end

`ifdef NOTE_DET_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_cnt <= '0;
        end else if (chg_nx) begin
            note_cnt <= note_cnt + 8'd1;
        end
    end
`else
    assign note_cnt = '0;
`endif

endmodule

// File: tb/tb_note_detector.sv
// Scoreboard bench for note_detector at a scaled-down clock rate; every
// expected note_chg event is queued by the stimulus and checked by a monitor.
module tb_note_detector;
    import note_pkg::*;

    localparam int unsigned CLK_HZ   = 250_000;
    localparam int          MUTE_CYC = 5000;
    localparam int          P_LA2    = 568;   // 250000/440
    localparam int          P_FA2    = 716;   // 250000/349.23
    localparam int          P_SOL2   = 638;   // 250000/392
    localparam int          P_UNK    = 625;   // 400 Hz, exactly on the sol2 lower bound

    typedef struct {
        logic [3:0] code;
        int         per;    // 0: period not checked
        int         n;      // note_chg pulses since reset including this one
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       nota = 1'b0;
    logic [3:0] note_code;
    logic       note_valid;
    logic       note_chg;
    logic [23:0] period;
    logic [7:0] note_cnt;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_n  = 0;

    note_detector #(
        .CLK_HZ     (CLK_HZ),
        .STABLE_CNT (3),
        .TOL_PCT    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nota       (nota),
        .note_code  (note_code),
        .note_valid (note_valid),
        .note_chg   (note_chg),
        .period     (period),
        .note_cnt   (note_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef NOTE_DET_CNT_EN
        return n % 256;
`else
        return 0;
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] code, input int per);
        exp_t e;
        exp_n++;
        e.code = code;
        e.per  = per;
        e.n    = exp_n;
        exp_q.push_back(e);
    endtask

    task automatic tone(input int p, input int reps);
        for (int r = 0; r < reps; r++) begin
            nota = 1'b1;
            step(p / 2);
            nota = 1'b0;
            step(p - p / 2);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1);
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: every note_chg pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (rst_n && note_chg) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected note_chg: code=%0d with nothing expected", note_code);
            end else begin
                e = exp_q.pop_front();
                chk("chg note_code", note_code, e.code);
                chk("chg note_valid", note_valid, 1);
                chk("chg note_cnt", note_cnt, exp_cnt(e.n));
                if (e.per > 0) begin
                    d = int'(period) - e.per;
                    checks++;
                    if (d < -1 || d > 1) begin
                        errors++;
                        $display("FAIL chg period: got %0d expected %0d", period, e.per);
                    end
                end
            end
        end
    end

    initial begin
        step(3);
        chk("reset note_code", note_code, 11);
        chk("reset note_valid", note_valid, 0);
        chk("reset note_chg", note_chg, 0);
        chk("reset period", period, 0);
        chk("reset note_cnt", note_cnt, 0);
        rst_n = 1'b1;
        step(2);

        // la2 from reset: one start edge plus three periods
        push(LA2_CODE, P_LA2);
        tone(P_LA2, 4);
        drain("drain la2");

        // fa2 then sol2
        push(FA2_CODE, P_FA2);
        push(SOL2_CODE, P_SOL2);
        tone(P_FA2, 4);
        tone(P_SOL2, 4);
        drain("drain fa2 sol2");
        chk("sol2 note_code", note_code, 10);

        // back to la2, then silence
        push(LA2_CODE, P_LA2);
        tone(P_LA2, 4);
        drain("drain la2 again");
        push(MUTE_CODE, 0);
        step(MUTE_CYC + 100);
        drain("drain mute");
        step(2 * MUTE_CYC);
        chk("mute note_code", note_code, 11);
        chk("mute note_valid", note_valid, 1);

        // 400 Hz lands exactly on a window boundary: unknown
        push(UNK_CODE, P_UNK);
        tone(P_UNK, 4);
        drain("drain unknown");

        // alternating fa2/la2 never stabilises
        for (int k = 0; k < 3; k++) begin
            tone(P_FA2, 1);
            tone(P_LA2, 1);
        end
        chk("alt note_code", note_code, 15);
        chk("alt note_valid", note_valid, 1);
        chk("alt period", period, P_FA2);

        // stable la2, then reset during the low half of a period
        push(LA2_CODE, P_LA2);
        tone(P_LA2, 4);
        drain("drain la2 pre-reset");
        nota = 1'b1;
        step(P_LA2 / 2);
        nota = 1'b0;
        step(100);
        rst_n = 1'b0;
        step(3);
        chk("midreset note_code", note_code, 11);
        chk("midreset note_valid", note_valid, 0);
        chk("midreset note_cnt", note_cnt, 0);
        chk("midreset period", period, 0);
        exp_n = 0;
        rst_n = 1'b1;
        step(P_LA2 - P_LA2 / 2 - 103);

        push(LA2_CODE, P_LA2);
        tone(P_LA2, 3);
        chk("post-reset 2 periods valid", note_valid, 0);
        tone(P_LA2, 1);
        drain("drain la2 post-reset");
        chk("post-reset note_code", note_code, 4);
        chk("post-reset note_valid", note_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_detector.md
NOTE_DETECTOR -- requirements
Module: note_detector

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter STABLE_CNT, default 3, consecutive matching periods required before a note is reported (range 1..7).
REQ-003 Parameter TOL_PCT, default 2, classification window half-width in percent of nominal period.
REQ-004 clk  in  1  system clock; one clock domain only.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 nota  in  1  square-wave tone input, asynchronous to clk; low level means silence.
REQ-007 note_code  out  4  current stable note code: 0 do2, 1 do3, 2 fa2, 3 la1, 4 la2, 5 mi2, 6 re2, 7 reb2, 8 reb3, 9 sib2, 10 sol2, 11 mute, 12 re1, 13 re3, 15 unknown.
REQ-008 note_valid  out  1  note_code has been confirmed stable since reset.
REQ-009 note_chg  out  1  one-cycle pulse when note_code takes a new value.
REQ-010 period  out  24  last measured nota period in clk cycles.
REQ-011 note_cnt  out  8  count of note_chg pulses (see Configuration).

Function
REQ-012 nota SHALL pass through a 2-FF synchronizer; a rising-edge pulse SHALL be derived from the synchronized value, 3 clk after the input edge.
REQ-013 FSM SHALL have states S_WAIT (no reference edge) and S_MEAS (counting since the last edge).
REQ-014 In S_WAIT, an edge pulse SHALL clear the cycle counter and enter S_MEAS.
REQ-015 In S_MEAS, the counter SHALL increment each clk, saturating at 24'hFFFFFF; on an edge pulse, period SHALL load counter+1, the counter SHALL restart, and the period SHALL be classified.
REQ-016 Classification SHALL return the code whose nominal period CLK_HZ/f is within ±TOL_PCT%; otherwise it SHALL return 15. f in Hz: re1 146.83, la1 220.00, do2 261.63, reb2 277.18, re2 293.66, mi2 329.63, fa2 349.23, sol2 392.00, la2 440.00, sib2 466.16, do3 523.25, reb3 554.37, re3 587.33.
REQ-017 Candidate tracking: a classified code equal to cand SHALL increment match_cnt (saturating at STABLE_CNT); otherwise cand SHALL load the code and match_cnt SHALL be set to 1.
REQ-018 When match_cnt reaches STABLE_CNT and (cand != note_code or note_valid=0), note_code SHALL load cand, note_valid SHALL be 1 and note_chg SHALL pulse on the next clk.
REQ-019 In S_MEAS, a counter reaching MUTE_CYC = CLK_HZ/50 (20 ms) SHALL force S_WAIT, cand=11 and match_cnt=STABLE_CNT, reporting mute per REQ-018 with no further periods needed.
REQ-020 An edge pulse and a timeout in the same cycle SHALL resolve as an edge.
REQ-021 A repeated identical stable code SHALL NOT re-pulse note_chg.

Reset
REQ-022 On rst_n low: state S_WAIT, counter 0, period 0, cand 11, match_cnt 0, note_code 11, note_valid 0, note_chg 0, note_cnt 0, synchronizer flops 0.
REQ-023 Reset asserted mid-measurement SHALL discard the partial period; the first edge after release SHALL only start a measurement.

Configuration
REQ-024 With NOTE_DET_CNT_EN defined, note_cnt SHALL increment (wrapping 255->0) on every note_chg pulse.
REQ-025 Without NOTE_DET_CNT_EN, the note_cnt port SHALL remain present, tied to 0, with no counter logic.

Structure
REQ-026 Package note_pkg SHALL hold the note code constants, the frequency table, MUTE_CODE=11, UNK_CODE=15 and the period-window function.
REQ-027 Sub-module note_classify (combinational: period in, code out) SHALL hold the window comparisons; the FSM, counters and stability logic stay in note_detector.

Verification (CLK_HZ=50e6 unless noted)
REQ-028 440 Hz square wave (113636-cycle period) after reset -> note_code=4, note_valid=1, one note_chg pulse after the 3rd complete period; period=113636±1.
REQ-029 349.23 Hz for 3 periods, then 392 Hz -> code 2, then code 10 after 3 sol2 periods; exactly two note_chg pulses.
REQ-030 la2 stable, nota held low for 1,000,000 cycles -> code 11 with one note_chg pulse; holding low longer -> no further pulses.
REQ-031 400 Hz input (125000 cycles, outside all windows) for 3 periods -> code 15, note_valid=1.
REQ-032 Alternating fa2/la2 periods -> note_code unchanged, no note_chg pulse.
REQ-033 rst_n pulsed low mid-period during stable la2 -> code 11, valid 0; re-reported only after 1 start edge plus 3 full periods; note_cnt=0 with NOTE_DET_CNT_EN defined.
